// File: rtl/vc_arb_pkg.sv
// Shared definitions for the interconnect arbiters: state encoding and small
// elaboration/encode helpers.
package vc_arb_pkg;

  typedef enum logic [0:0] {ArbIdle, ArbOwned} arb_state_e;

  // Ceiling log2, never less than 1 so that every derived vector has a bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

  // One-hot (up to 32 bits) to binary; zero input encodes to 0.
  function automatic int unsigned oh2bin(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/vc_rr_arb_pick.sv
// Combinational round-robin pick: first asserted request at or above ptr,
// wrapping. Double-width find-first avoids a rotate barrel.
module vc_rr_arb_pick
  import vc_arb_pkg::*;
#(
  parameter int unsigned p_num_reqs = 4,
  parameter int unsigned p_idx_w    = clog2(p_num_reqs)
) (
  input  logic [p_num_reqs-1:0] reqs,
  input  logic [p_idx_w-1:0]    ptr,
  output logic [p_num_reqs-1:0] pick,
  output logic                  valid
);

  logic [2*p_num_reqs-1:0] dbl;
  logic [2*p_num_reqs-1:0] first;
  logic                    found;

  always_comb begin
    // Lower copy keeps only indices >= ptr; upper copy supplies the wrap.
    for (int unsigned i = 0; i < p_num_reqs; i++) begin
      dbl[i]              = reqs[i] & (p_idx_w'(i) >= ptr);
      dbl[p_num_reqs + i] = reqs[i];
    end
    first = '0;
    found = 1'b0;
    for (int unsigned j = 0; j < 2 * p_num_reqs; j++) begin
      if (dbl[j] && !found) begin
        first[j] = 1'b1;
        found    = 1'b1;
      end
    end
    pick  = first[p_num_reqs-1:0] | first[2*p_num_reqs-1:p_num_reqs];
    valid = |reqs;
  end

endmodule

// File: rtl/vc_rr_arb_hold.sv
// Round-robin arbiter with registered one-hot grant and bounded grant locking.
// Supports up to 32 requesters.
module vc_rr_arb_hold
  import vc_arb_pkg::*;
#(
  parameter int unsigned p_num_reqs = 4,
  parameter int unsigned p_max_hold = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             en,
  input  logic [p_num_reqs-1:0]            reqs,
  input  logic [p_num_reqs-1:0]            locks,
  output logic [p_num_reqs-1:0]            grants,
  output logic                             grant_val,
  output logic [clog2(p_num_reqs)-1:0]     grant_idx
);

  localparam int unsigned IdxW  = clog2(p_num_reqs);
  localparam int unsigned HoldW = clog2(p_max_hold + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(p_max_hold);
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(p_num_reqs - 1);

  arb_state_e             state_q, state_d;
  logic [IdxW-1:0]        ptr_q, ptr_d;
  logic [p_num_reqs-1:0]  grants_q, grants_d;
  logic [HoldW-1:0]       hold_q, hold_d;

  logic [p_num_reqs-1:0]  pick;
  logic                   pick_any;
  logic [IdxW-1:0]        pick_idx;
  logic                   others;
  logic                   keep;

  vc_rr_arb_pick #(
    .p_num_reqs (p_num_reqs),
    .p_idx_w    (IdxW)
  ) u_pick (
    .reqs  (reqs),
    .ptr   (ptr_q),
    .pick  (pick),
    .valid (pick_any)
  );

  assign pick_idx = IdxW'(oh2bin(32'(pick)));
  assign others   = |(reqs & ~grants_q);
  // hold_q saturates at HoldMax, so "below the limit" is simply "not at it".
  assign keep     = (state_q == ArbOwned) && (|(reqs & locks & grants_q)) &&
                    ((p_max_hold == 0) || (hold_q != HoldMax) || !others);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grants_d = grants_q;
    hold_d   = hold_q;
    if (!en) begin
      state_d  = ArbIdle;
      grants_d = '0;
      hold_d   = '0;
    end else if (keep) begin
      hold_d = (hold_q == HoldMax) ? hold_q : hold_q + HoldW'(1);
    end else if (pick_any) begin
      state_d  = ArbOwned;
      grants_d = pick;
      ptr_d    = (pick_idx == LastIdx) ? '0 : pick_idx + IdxW'(1);
      hold_d   = '0;
    end else begin
      state_d  = ArbIdle;
      grants_d = '0;
      hold_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ArbIdle;
      ptr_q    <= '0;
      grants_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grants_q <= grants_d;
      hold_q   <= hold_d;
    end
  end

  assign grants    = grants_q;
  assign grant_val = |grants_q;
  assign grant_idx = IdxW'(oh2bin(32'(grants_q)));

endmodule

// File: tb/tb_vc_rr_arb_hold.sv
// Bench for vc_rr_arb_hold: directed vector table and random stimulus against
// a behavioural model on a 4-requester/hold-2 instance, plus a 3-requester
// unlimited-hold instance for wrap and asynchronous reset corners.
module tb_vc_rr_arb_hold;

  localparam int NA = 4;
  localparam int HA = 2;
  localparam int NB = 3;

  logic          clk;
  logic          rst_a_n, en_a;
  logic [NA-1:0] reqs_a, locks_a, grants_a;
  logic          val_a;
  logic [1:0]    idx_a;
  logic          rst_b_n, en_b;
  logic [NB-1:0] reqs_b, locks_b, grants_b;
  logic          val_b;
  logic [1:0]    idx_b;

  int passes = 0;
  int total  = 0;

  typedef struct {
    logic          en;
    logic [NA-1:0] reqs;
    logic [NA-1:0] locks;
    logic [NA-1:0] exp;
  } vec_t;
  vec_t vecs[$];

  vc_rr_arb_hold #(.p_num_reqs(NA), .p_max_hold(HA)) dut_a (
    .clk(clk), .reset_n(rst_a_n), .en(en_a), .reqs(reqs_a), .locks(locks_a),
    .grants(grants_a), .grant_val(val_a), .grant_idx(idx_a)
  );

  vc_rr_arb_hold #(.p_num_reqs(NB), .p_max_hold(0)) dut_b (
    .clk(clk), .reset_n(rst_b_n), .en(en_b), .reqs(reqs_b), .locks(locks_b),
    .grants(grants_b), .grant_val(val_b), .grant_idx(idx_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  function automatic int oh_idx(input logic [31:0] v);
    int r = 0;
    for (int i = 0; i < 32; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic check_a(input string name, input logic [NA-1:0] exp);
    check({name, ".grants"}, 32'(grants_a), 32'(exp));
    check({name, ".val"}, 32'(val_a), 32'(exp != 0));
    check({name, ".idx"}, 32'(idx_a), 32'(oh_idx(32'(exp))));
  endtask

  task automatic check_b(input string name, input logic [NB-1:0] exp);
    check({name, ".grants"}, 32'(grants_b), 32'(exp));
    check({name, ".val"}, 32'(val_b), 32'(exp != 0));
    check({name, ".idx"}, 32'(idx_b), 32'(oh_idx(32'(exp))));
  endtask

  task automatic add(input logic e, input logic [NA-1:0] r, input logic [NA-1:0] l,
                     input logic [NA-1:0] x);
    vecs.push_back('{en: e, reqs: r, locks: l, exp: x});
  endtask

  // Behavioural model state: grantee index (-1 = none), priority start, lock age.
  int m_g, m_ptr, m_hold;

  task automatic model_step(input logic e, input logic [NA-1:0] r, input logic [NA-1:0] l);
    bit keep, found;
    int c;
    if (!e) begin
      m_g = -1;
      m_hold = 0;
    end else begin
      keep = (m_g >= 0) && r[m_g] && l[m_g] &&
             (HA == 0 || m_hold < HA || (r & ~(4'(1) << m_g)) == 0);
      if (keep) begin
        m_hold = (m_hold + 1 > HA) ? HA : m_hold + 1;
      end else if (r != 0) begin
        found = 0;
        for (int k = 0; k < NA; k++) begin
          c = (m_ptr + k) % NA;
          if (!found && r[c]) begin
            m_g = c;
            found = 1;
          end
        end
        m_ptr = (m_g + 1) % NA;
        m_hold = 0;
      end else begin
        m_g = -1;
        m_hold = 0;
      end
    end
  endtask

  initial begin
    logic [NA-1:0] exp_g;
    rst_a_n = 1'b0; en_a = 1'b0; reqs_a = '0; locks_a = '0;
    rst_b_n = 1'b0; en_b = 1'b0; reqs_b = '0; locks_b = '0;
    #12;
    check_a("reset_a", 4'b0000);
    check_b("reset_b", 3'b000);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;

    // Rotation with no locks
    repeat (2) begin
      add(1, 4'b1111, 4'b0000, 4'b0001); add(1, 4'b1111, 4'b0000, 4'b0010);
    end
    vecs[2].exp = 4'b0100; vecs[3].exp = 4'b1000;
    add(1, 4'b1111, 4'b0000, 4'b0001);
    // Single requester held
    repeat (5) add(1, 4'b0100, 4'b0000, 4'b0100);
    add(1, 4'b0000, 4'b0000, 4'b0000);
    // Lock limit: 0001 lasts exactly three cycles while others wait
    add(1, 4'b1000, 4'b0000, 4'b1000);
    repeat (3) add(1, 4'b1111, 4'b0001, 4'b0001);
    add(1, 4'b1111, 4'b0001, 4'b0010);
    // Lone locked requester persists past the limit
    repeat (5) add(1, 4'b0001, 4'b0001, 4'b0001);
    // Grantee drop hands over with no bubble, then idle
    add(1, 4'b1000, 4'b0000, 4'b1000);
    add(1, 4'b0011, 4'b0000, 4'b0001);
    add(1, 4'b0010, 4'b0000, 4'b0010);
    add(1, 4'b0000, 4'b0000, 4'b0000);
    add(1, 4'b0000, 4'b0000, 4'b0000);
    // en drop breaks a lock on index 2 and beats new requests; ptr preserved
    add(1, 4'b0100, 4'b0100, 4'b0100);
    add(1, 4'b0100, 4'b0100, 4'b0100);
    add(0, 4'b1111, 4'b0100, 4'b0000);
    add(1, 4'b1111, 4'b0000, 4'b1000);
    add(1, 4'b1111, 4'b0000, 4'b0001);

    for (int i = 0; i < vecs.size(); i++) begin
      en_a = vecs[i].en; reqs_a = vecs[i].reqs; locks_a = vecs[i].locks;
      @(posedge clk); #1;
      check_a($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Random stimulus against the model, from a fresh reset
    en_a = 1'b0; reqs_a = '0; locks_a = '0;
    rst_a_n = 1'b0; #2; rst_a_n = 1'b1;
    m_g = -1; m_ptr = 0; m_hold = 0;
    for (int i = 0; i < 400; i++) begin
      en_a    = ($urandom_range(0, 9) != 0);
      reqs_a  = NA'($urandom);
      locks_a = NA'($urandom | $urandom);
      model_step(en_a, reqs_a, locks_a);
      @(posedge clk); #1;
      exp_g = (m_g < 0) ? '0 : NA'(1) << m_g;
      check_a($sformatf("rnd%0d", i), exp_g);
    end
    en_a = 1'b0; reqs_a = '0; locks_a = '0;

    // N = 3 wrap, asynchronous reset mid-rotation, unlimited lock
    en_b = 1'b1; reqs_b = 3'b111; locks_b = 3'b000;
    @(posedge clk); #1; check_b("n3_r0", 3'b001);
    @(posedge clk); #1; check_b("n3_r1", 3'b010);
    @(posedge clk); #1; check_b("n3_r2", 3'b100);
    @(posedge clk); #1; check_b("n3_r3", 3'b001);
    #3; rst_b_n = 1'b0;
    #1; check_b("n3_async_rst", 3'b000);
    #2; rst_b_n = 1'b1;
    @(posedge clk); #1; check_b("n3_restart", 3'b001);
    locks_b = 3'b001;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1; check_b($sformatf("n3_lock%0d", i), 3'b001);
    end
    locks_b = 3'b000;
    @(posedge clk); #1; check_b("n3_unlock", 3'b010);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
